// File: rtl/game_pkg.sv
// Shared definitions for the colour-sequence game: colour codes, button FSM
// states and small one-hot helpers used by the input stage and later stages.
package game_pkg;

  localparam logic [1:0] COL_0 = 2'b00;
  localparam logic [1:0] COL_1 = 2'b01;
  localparam logic [1:0] COL_2 = 2'b10;
  localparam logic [1:0] COL_3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } btn_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = COL_1;
      4'b0100: idx = COL_2;
      4'b1000: idx = COL_3;
      default: idx = COL_0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous inputs; free-running, cleared by reset.
module btn_sync #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage p0 -> p1 boundary
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/button_input.sv
// Button front end: synchronise, debounce and one-hot-check four buttons and
// emit one registered colour strobe per clean press-and-release.
module button_input
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn,
  output logic       colour_in,
  output logic [1:0] colour_val,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       btn_s;
  btn_state_t       state;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  btn_sync #(
    .DATA_W(4)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_s)
  );

  assign cand_mask = 4'b0001 << cand;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cand       <= COL_0;
      cnt        <= '0;
      colour_in  <= 1'b0;
      colour_val <= COL_0;
      busy       <= 1'b0;
    end else begin
      colour_in <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_onehot4(btn_s)) begin
              cand  <= onehot_idx(btn_s);
              cnt   <= CNT_ONE;
              state <= ST_PRESS_DB;
              busy  <= 1'b1;
            end
          end
          ST_PRESS_DB: begin
            if (btn_s == cand_mask) begin
              cnt <= sat_inc(cnt);
              // strobe in the same edge the count reaches the threshold
              if (cnt == CNT_LAST) begin
                state      <= ST_HELD;
                colour_in  <= 1'b1;
                colour_val <= cand;
              end
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end
          ST_HELD: begin
            if (btn_s == 4'd0) begin
              cnt   <= CNT_ONE;
              state <= ST_RELEASE_DB;
            end
          end
          ST_RELEASE_DB: begin
            if (btn_s == 4'd0) begin
              cnt <= sat_inc(cnt);
              if (cnt == CNT_LAST) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              state <= ST_HELD;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_input.sv
// Self-checking bench for button_input with DEBOUNCE_CYCLES = 4: directed
// table scenarios, hand-written corner sequences and randomized stimulus.
module tb_button_input;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] btn;
  logic       colour_in;
  logic [1:0] colour_val;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  logic [7:0] seq_log = 8'd0;

  // reference model state
  logic [3:0] m_s1, m_s2;
  int         m_streak, m_rel;
  logic [1:0] m_cand;
  bit         m_latched;
  logic       m_strobe;
  logic [1:0] m_val;
  logic       m_busy;

  button_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .btn        (btn),
    .colour_in  (colour_in),
    .colour_val (colour_val),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] btn;
    int         ncyc;
    int         exp_strobes;
    logic [1:0] exp_val;
    logic       exp_busy;
  } vec_t;

  function automatic bit onehot(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_s1 = 4'd0; m_s2 = 4'd0; m_streak = 0; m_rel = 0; m_cand = 2'd0;
    m_latched = 1'b0; m_strobe = 1'b0; m_val = 2'd0; m_busy = 1'b0;
  endtask

  // Streak-based view: a one-hot value seen D edges in a row while armed is
  // accepted; then D all-zero edges in a row re-arm the block.
  task automatic model_step(input logic [3:0] b, input logic e, input logic r);
    logic [3:0] bs;
    bs = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    if (!r) begin
      model_reset();
      return;
    end
    m_strobe = 1'b0;
    if (!e) begin
      m_streak = 0; m_latched = 1'b0; m_rel = 0;
    end else if (!m_latched) begin
      if (m_streak > 0) begin
        if (bs == (4'd1 << m_cand)) m_streak++;
        else m_streak = 0;
      end else if (onehot(bs)) begin
        m_streak = 1;
        m_cand = idx_of(bs);
      end
      if (m_streak == D) begin
        m_strobe = 1'b1; m_val = m_cand; m_latched = 1'b1; m_streak = 0; m_rel = 0;
      end
    end else begin
      if (bs == 4'd0) m_rel++;
      else m_rel = 0;
      if (m_rel == D) begin
        m_latched = 1'b0; m_rel = 0;
      end
    end
    m_busy = (m_streak > 0) || m_latched;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, step the model at the rising edge, compare
  // at the next falling edge.
  task automatic cycle(input logic [3:0] b, input logic e, input logic r);
    btn = b; en = e; rst = r;
    @(posedge clk);
    model_step(b, e, r);
    @(negedge clk);
    check("model_colour_in", int'(colour_in), int'(m_strobe));
    check("model_colour_val", int'(colour_val), int'(m_val));
    check("model_busy", int'(busy), int'(m_busy));
    if (colour_in) begin
      strobes++;
      seq_log = {seq_log[5:0], colour_val};
    end
  endtask

  vec_t vecs[8];
  int   s0, first_k;
  logic [3:0] rb;
  logic re, rr;

  initial begin
    btn = 4'd0; en = 1'b0; rst = 1'b0;
    model_reset();
    @(negedge clk);
    cycle(4'd0, 1'b0, 1'b0);
    cycle(4'd0, 1'b1, 1'b0);
    check("reset_colour_in", int'(colour_in), 0);
    check("reset_colour_val", int'(colour_val), 0);
    check("reset_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) cycle(4'd0, 1'b1, 1'b1);

    // directed table: {en, btn, cycles, strobes, colour_val, busy at end}
    vecs[0] = '{1'b1, 4'b0100, 20, 1, 2'b10, 1'b1};
    vecs[1] = '{1'b1, 4'b0000, 20, 0, 2'b10, 1'b0};
    vecs[2] = '{1'b1, 4'b1001, 20, 0, 2'b10, 1'b0};
    vecs[3] = '{1'b1, 4'b1000, 20, 1, 2'b11, 1'b1};
    vecs[4] = '{1'b1, 4'b0000, 20, 0, 2'b11, 1'b0};
    vecs[5] = '{1'b0, 4'b0001, 20, 0, 2'b11, 1'b0};
    vecs[6] = '{1'b1, 4'b0001,  8, 1, 2'b00, 1'b1};
    vecs[7] = '{1'b1, 4'b0000, 20, 0, 2'b00, 1'b0};
    for (int v = 0; v < 8; v++) begin
      s0 = strobes;
      for (int c = 0; c < vecs[v].ncyc; c++) cycle(vecs[v].btn, vecs[v].en, 1'b1);
      check($sformatf("table%0d_strobes", v), strobes - s0, vecs[v].exp_strobes);
      check($sformatf("table%0d_val", v), int'(colour_val), int'(vecs[v].exp_val));
      check($sformatf("table%0d_busy", v), int'(busy), int'(vecs[v].exp_busy));
    end

    // press latency: strobe visible in the 6th cycle after the first sampling edge
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(4'b0100, 1'b1, 1'b1);
      if (colour_in && first_k == 0) first_k = k;
    end
    check("press_latency", first_k, 6);
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(4'b0000, 1'b1, 1'b1);
      if (!busy && first_k == 0) first_k = k;
    end
    check("release_latency", first_k, 6);

    // bounce on btn[1]
    s0 = strobes;
    cycle(4'b0010, 1'b1, 1'b1); cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 1'b1, 1'b1); cycle(4'b0010, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1); cycle(4'b0010, 1'b1, 1'b1);
    check("bounce_no_early_strobe", strobes - s0, 0);
    for (int c = 0; c < 10; c++) cycle(4'b0010, 1'b1, 1'b1);
    check("bounce_one_strobe", strobes - s0, 1);
    check("bounce_val", int'(colour_val), 1);
    for (int c = 0; c < 12; c++) cycle(4'b0000, 1'b1, 1'b1);

    // sequence 3,2,3,3 with full releases
    s0 = strobes;
    seq_log = 8'd0;
    for (int p = 0; p < 4; p++) begin
      rb = (p == 1) ? 4'b0100 : 4'b1000;
      for (int c = 0; c < 10; c++) cycle(rb, 1'b1, 1'b1);
      for (int c = 0; c < 12; c++) cycle(4'b0000, 1'b1, 1'b1);
    end
    check("seq_strobes", strobes - s0, 4);
    check("seq_codes", int'(seq_log), int'(8'b11_10_11_11));

    // reset mid-press
    for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b1, 1'b1);
    check("midpress_busy", int'(busy), 1);
    cycle(4'b0100, 1'b1, 1'b0);
    check("midpress_rst_colour_in", int'(colour_in), 0);
    check("midpress_rst_val", int'(colour_val), 0);
    check("midpress_rst_busy", int'(busy), 0);
    s0 = strobes;
    for (int c = 0; c < 12; c++) cycle(4'b0100, 1'b1, 1'b1);
    check("midpress_restrobe", strobes - s0, 1);
    check("midpress_val", int'(colour_val), 2);
    for (int c = 0; c < 12; c++) cycle(4'b0000, 1'b1, 1'b1);

    // randomized stimulus against the model
    rb = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 15) begin
        case ($urandom_range(0, 2))
          0: rb = 4'd0;
          1: rb = 4'd1 << $urandom_range(0, 3);
          default: rb = 4'($urandom_range(0, 15));
        endcase
      end
      re = ($urandom_range(0, 99) >= 3);
      rr = ($urandom_range(0, 199) != 0);
      cycle(rb, re, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
